// File: rtl/hex_disp_pkg.sv
// Shared constants, FSM state type and BCD sizing helper for the hex/decimal
// display driver.
package hex_disp_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_OVF = 4'hE;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StCommit
  } state_e;

  // Decimal digits needed for a data_w-bit binary value: floor(data_w*log10(2))+1
  // (7 for 20 bits, enough for 1048575).
  function automatic int unsigned bcd_digits(input int unsigned data_w);
    return (data_w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/hex_display_driver_if.sv
// Valid/ready input channel carrying a binary value plus display mode flags.
interface hex_display_driver_if #(
  parameter int unsigned DATA_W = 20
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_dec_mode;
  logic              in_lz_en;

  modport master (
    output in_valid,
    output in_data,
    output in_dec_mode,
    output in_lz_en,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_dec_mode,
    input  in_lz_en,
    output in_ready
  );

endinterface

// File: rtl/bin2bcd_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift the
// next binary bit in at the bottom.
module bin2bcd_step
  import hex_disp_pkg::*;
#(
  parameter int unsigned NumDigits = 7
) (
  input  logic [NumDigits*DIGIT_W-1:0] bcd_i,
  input  logic                         bit_i,
  output logic [NumDigits*DIGIT_W-1:0] bcd_o
);

  localparam int unsigned BcdW = NumDigits * DIGIT_W;

  logic [BcdW-1:0] adj;
  logic            unused_msb;

  always_comb begin
    adj = bcd_i;
    for (int i = 0; i < NumDigits; i++) begin
      if (bcd_i[i*DIGIT_W +: DIGIT_W] >= 4'd5) begin
        adj[i*DIGIT_W +: DIGIT_W] = bcd_i[i*DIGIT_W +: DIGIT_W] + 4'd3;
      end
    end
  end

  // The register is sized so the top bit never carries real data out.
  assign bcd_o      = {adj[BcdW-2:0], bit_i};
  assign unused_msb = adj[BcdW-1];

endmodule

// File: rtl/hex_display_driver.sv
// Converts a binary value to per-digit nibbles (hex split or sequential BCD)
// with leading-zero blanking and overflow indication.
module hex_display_driver
  import hex_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DATA_W     = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  hex_display_driver_if.slave           in_if,
  output logic [DIGIT_W*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]         blank_o,
  output logic                          ovf_o,
  output logic                          upd_o,
  output logic                          busy_o
);

  localparam int unsigned DigW = DIGIT_W * NUM_DIGITS;
  localparam int unsigned BcdD = bcd_digits(DATA_W);
  // Keep at least one digit above the display so the overflow slice is never empty.
  localparam int unsigned BcdN = (BcdD > NUM_DIGITS) ? BcdD : NUM_DIGITS + 1;
  localparam int unsigned BcdW = BcdN * DIGIT_W;
  localparam int unsigned CntW = $clog2(DATA_W + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              lz_q, lz_d;
  logic              ready_q, ready_d;
  logic [DigW-1:0]   digits_q, digits_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic              ovf_q, ovf_d;
  logic              upd_q, upd_d;

  logic                   xfer;
  logic [DigW+DATA_W-1:0] hex_ext;
  logic                   hex_ovf;
  logic                   dec_ovf;
  logic [BcdW-1:0]        bcd_step;
  logic                   load;
  logic                   force_ovf;
  logic [DigW-1:0]        new_digits;
  logic                   new_lz;
  logic                   zero_run;
  logic [NUM_DIGITS-1:0]  new_blank;

  assign xfer    = in_if.in_valid && ready_q;
  assign hex_ext = {{DigW{1'b0}}, in_if.in_data};
  assign hex_ovf = |hex_ext[DigW +: DATA_W];
  assign dec_ovf = |bcd_q[BcdW-1:DigW];

  bin2bcd_step #(
    .NumDigits(BcdN)
  ) u_step (
    .bcd_i(bcd_q),
    .bit_i(bin_q[DATA_W-1]),
    .bcd_o(bcd_step)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    lz_d       = lz_q;
    digits_d   = digits_q;
    blank_d    = blank_q;
    ovf_d      = ovf_q;
    upd_d      = 1'b0;
    load       = 1'b0;
    force_ovf  = 1'b0;
    new_digits = hex_ext[DigW-1:0];
    new_lz     = in_if.in_lz_en;
    zero_run   = 1'b1;
    new_blank  = '0;

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (in_if.in_dec_mode) begin
            bin_d   = in_if.in_data;
            bcd_d   = '0;
            lz_d    = in_if.in_lz_en;
            cnt_d   = CntW'(DATA_W);
            state_d = StConv;
          end else begin
            load  = 1'b1;
            ovf_d = hex_ovf;
          end
        end
      end
      StConv: begin
        bcd_d = bcd_step;
        bin_d = {bin_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        load       = 1'b1;
        force_ovf  = dec_ovf;
        ovf_d      = dec_ovf;
        new_digits = bcd_q[DigW-1:0];
        new_lz     = lz_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Scan from the most significant digit; a digit is dark while everything
    // above it (and itself) is zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (new_digits[i*DIGIT_W +: DIGIT_W] == '0);
      new_blank[i] = new_lz & zero_run & (i != 0);
    end

    if (load) begin
      upd_d = 1'b1;
      if (force_ovf) begin
        digits_d = {NUM_DIGITS{DIGIT_OVF}};
        blank_d  = '0;
      end else begin
        digits_d = new_digits;
        blank_d  = new_blank;
      end
    end

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      lz_q     <= 1'b0;
      ready_q  <= 1'b0;
      digits_q <= '0;
      blank_q  <= '1;
      ovf_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      lz_q     <= lz_d;
      ready_q  <= ready_d;
      digits_q <= digits_d;
      blank_q  <= blank_d;
      ovf_q    <= ovf_d;
      upd_q    <= upd_d;
    end
  end

  assign in_if.in_ready = ready_q;
  assign digits_o       = digits_q;
  assign blank_o        = blank_q;
  assign ovf_o          = ovf_q;
  assign upd_o          = upd_q;
  assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed bench for hex_display_driver: hex split, decimal conversion,
// blanking, overflow, back-pressure and reset abort.
module tb_hex_display_driver;

  logic        clk;
  logic        rst_n;
  logic [23:0] digits_o;
  logic [5:0]  blank_o;
  logic        ovf_o;
  logic        upd_o;
  logic        busy_o;

  int n_checks;
  int n_errors;

  hex_display_driver_if #(.DATA_W(20)) bus ();

  hex_display_driver #(
    .NUM_DIGITS(6),
    .DATA_W    (20)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_if   (bus),
    .digits_o(digits_o),
    .blank_o (blank_o),
    .ovf_o   (ovf_o),
    .upd_o   (upd_o),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_dec(input string tag, input logic [19:0] val, input logic lz,
                         input logic [23:0] exp_dig, input logic [5:0] exp_blank,
                         input logic exp_ovf);
    int   n;
    int   lows;
    int   upd_at;
    logic busy_ok;
    check({tag, " ready before"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid    = 1'b1;
    bus.in_data     = val;
    bus.in_dec_mode = 1'b1;
    bus.in_lz_en    = lz;
    n       = 0;
    lows    = 0;
    upd_at  = 0;
    busy_ok = 1'b1;
    while (upd_at == 0 && n < 40) begin
      step();
      n++;
      if (n == 1) bus.in_valid = 1'b0;
      if (upd_o) begin
        upd_at = n;
      end else begin
        if (!bus.in_ready) lows++;
        if (busy_o !== ~bus.in_ready) busy_ok = 1'b0;
      end
    end
    check({tag, " upd edge"}, 32'(upd_at), 32'd22);
    check({tag, " ready low"}, 32'(lows), 32'd21);
    check({tag, " busy"}, 32'(busy_ok), 32'd1);
    check({tag, " digits"}, 32'(digits_o), 32'(exp_dig));
    check({tag, " blank"}, 32'(blank_o), 32'(exp_blank));
    check({tag, " ovf"}, 32'(ovf_o), 32'(exp_ovf));
    step();
    check({tag, " upd pulse"}, 32'(upd_o), 32'd0);
    check({tag, " hold"}, 32'(digits_o), 32'(exp_dig));
  endtask

  initial begin
    int n;
    int upd1;
    int upd2;
    int upd_cnt;
    logic [23:0] d1;
    logic [23:0] d2;
    logic [5:0]  b2;

    n_checks        = 0;
    n_errors        = 0;
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_dec_mode = 1'b0;
    bus.in_lz_en    = 1'b0;

    // Reset
    repeat (3) step();
    check("rst ready", 32'(bus.in_ready), 32'd0);
    check("rst digits", 32'(digits_o), 32'h0);
    check("rst blank", 32'(blank_o), 32'h3f);
    check("rst ovf", 32'(ovf_o), 32'd0);
    check("rst upd", 32'(upd_o), 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    step();
    check("post rst ready", 32'(bus.in_ready), 32'd1);

    // Hex, back-to-back
    bus.in_valid = 1'b1;
    bus.in_data  = 20'hABCDE;
    step();
    check("hex1 digits", 32'(digits_o), 32'h0ABCDE);
    check("hex1 blank", 32'(blank_o), 32'h00);
    check("hex1 ovf", 32'(ovf_o), 32'd0);
    check("hex1 upd", 32'(upd_o), 32'd1);
    check("hex1 ready", 32'(bus.in_ready), 32'd1);
    bus.in_data  = 20'h12345;
    bus.in_lz_en = 1'b1;
    step();
    check("hex2 digits", 32'(digits_o), 32'h012345);
    check("hex2 blank", 32'(blank_o), 32'h20);
    check("hex2 upd", 32'(upd_o), 32'd1);
    bus.in_data = 20'h00007;
    step();
    check("hex3 digits", 32'(digits_o), 32'h000007);
    check("hex3 blank", 32'(blank_o), 32'h3e);
    bus.in_valid = 1'b0;
    step();
    check("hex idle upd", 32'(upd_o), 32'd0);
    check("hex idle hold", 32'(digits_o), 32'h000007);

    // Decimal vectors
    run_dec("dec123456", 20'd123456, 1'b0, 24'h123456, 6'b000000, 1'b0);
    run_dec("dec42", 20'd42, 1'b1, 24'h000042, 6'b111100, 1'b0);
    run_dec("dec0", 20'd0, 1'b1, 24'h000000, 6'b111110, 1'b0);
    run_dec("dec1000000", 20'd1000000, 1'b1, 24'hEEEEEE, 6'b000000, 1'b1);
    run_dec("dec999999", 20'd999999, 1'b0, 24'h999999, 6'b000000, 1'b0);
    run_dec("dec1048575", 20'hFFFFF, 1'b1, 24'hEEEEEE, 6'b000000, 1'b1);

    // Second value queued behind a decimal conversion
    bus.in_valid    = 1'b1;
    bus.in_data     = 20'd777;
    bus.in_dec_mode = 1'b1;
    bus.in_lz_en    = 1'b0;
    upd1 = 0;
    upd2 = 0;
    d1   = '0;
    d2   = '0;
    b2   = '0;
    n    = 0;
    while (upd2 == 0 && n < 80) begin
      step();
      n++;
      if (n == 1) begin
        bus.in_data  = 20'd31;
        bus.in_lz_en = 1'b1;
      end
      if (upd_o && upd1 == 0) begin
        upd1 = n;
        d1   = digits_o;
      end else if (upd_o) begin
        upd2 = n;
        d2   = digits_o;
        b2   = blank_o;
      end
      if (upd1 != 0 && n == upd1 + 1) bus.in_valid = 1'b0;
    end
    check("queue upd1 edge", 32'(upd1), 32'd22);
    check("queue first digits", 32'(d1), 32'h000777);
    check("queue upd2 edge", 32'(upd2), 32'd44);
    check("queue second digits", 32'(d2), 32'h000031);
    check("queue second blank", 32'(b2), 32'h3c);

    // Reset during conversion
    bus.in_valid    = 1'b1;
    bus.in_data     = 20'd654321;
    bus.in_dec_mode = 1'b1;
    bus.in_lz_en    = 1'b0;
    step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    check("abort busy before", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    step();
    check("abort busy", 32'(busy_o), 32'd0);
    check("abort ready", 32'(bus.in_ready), 32'd0);
    check("abort digits", 32'(digits_o), 32'h0);
    check("abort blank", 32'(blank_o), 32'h3f);
    check("abort upd", 32'(upd_o), 32'd0);
    step();
    rst_n   = 1'b1;
    upd_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (upd_o) upd_cnt++;
    end
    check("abort no upd", 32'(upd_cnt), 32'd0);
    check("abort digits hold", 32'(digits_o), 32'h0);
    run_dec("after abort", 20'd654321, 1'b0, 24'h654321, 6'b000000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
